// File: rtl/block_scheduler_pkg.sv
// Shared types for the block scheduler: launch config, FSM state encodings
// and a popcount helper used to total simultaneous block completions.
// Latency: n/a (types only). Backpressure: n/a.
package block_scheduler_pkg;

  // Width of block ids carried in the launch config; num_blocks has one
  // extra bit so a full 2^CFG_ID_WIDTH block kernel can be expressed.
  localparam int CFG_ID_WIDTH = 8;

  typedef struct packed {
    logic [CFG_ID_WIDTH:0] num_blocks;
  } kernel_config_t;

  typedef enum logic [1:0] {IDLE, RUN, DONE} sched_state_t;

  typedef enum logic [1:0] {FREE, RST, ACTIVE} slot_state_t;

  function automatic int popcount(input logic [15:0] v);
    int c;
    c = 0;
    for (int i = 0; i < 16; i++) begin
      c += v[i] ? 1 : 0;
    end
    return c;
  endfunction

endpackage

// File: rtl/core_slot.sv
// One core slot: FREE -> RST (1 cycle core_reset) -> ACTIVE (core_start) -> FREE.
// Latency: core_reset 1 cycle after dispatch, core_start 1 cycle after that.
// Backpressure: none; core_done is honoured only while ACTIVE.
// Ports: clk/reset; dispatch+block_id from the selector; run = kernel running;
//   kill forces RST (abort); core_done from the core; is_free/completed to the
//   selector and popcount; core_start/core_reset/core_block_id drive the core.
module core_slot
  import block_scheduler_pkg::*;
#(
  parameter int BLOCK_ID_WIDTH = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      dispatch,
  input  logic [BLOCK_ID_WIDTH-1:0] block_id,
  input  logic                      run,
  input  logic                      kill,
  input  logic                      core_done,
  output logic                      is_free,
  output logic                      completed,
  output logic                      core_start,
  output logic                      core_reset,
  output logic [BLOCK_ID_WIDTH-1:0] core_block_id
);

  slot_state_t state;

  assign is_free   = (state == FREE);
  assign completed = (state == ACTIVE) && core_done;

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= FREE;
      core_reset    <= 1'b1;
      core_start    <= 1'b0;
      core_block_id <= '0;
    end else if (kill) begin
      state      <= RST;
      core_reset <= 1'b1;
      core_start <= 1'b0;
    end else begin
      case (state)
        FREE: begin
          if (dispatch) begin
            state         <= RST;
            core_reset    <= 1'b1;
            core_block_id <= block_id;
          end else begin
            // also clears the reset-time core_reset pulse
            core_reset <= 1'b0;
          end
        end
        RST: begin
          core_reset <= 1'b0;
          // after an abort the kernel is gone, so the slot parks instead of running
          if (run) begin
            state      <= ACTIVE;
            core_start <= 1'b1;
          end else begin
            state <= FREE;
          end
        end
        ACTIVE: begin
          if (core_done) begin
            state      <= FREE;
            core_start <= 1'b0;
          end
        end
        default: begin
          state      <= FREE;
          core_reset <= 1'b0;
          core_start <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/block_scheduler.sv
// Kernel block scheduler: hands sequential block ids to free core slots and
// counts completions until the kernel is done. Latency: dispatch decision to
// core_reset 1 cycle; last completion to done 2 cycles. Backpressure: none;
// start is ignored while RUN, abort wins over start.
// Ports: clk/reset; start/abort/kernel_config control; core_done per core in;
//   core_start/core_reset/core_block_id per core out; busy/done/blocks_done status.
module block_scheduler
  import block_scheduler_pkg::*;
#(
  parameter int NUM_CORES        = 2,
  parameter int BLOCK_ID_WIDTH   = 8,
  parameter int LAUNCH_PER_CYCLE = 1
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                start,
  input  logic                                abort,
  input  kernel_config_t                      kernel_config,
  input  logic [NUM_CORES-1:0]                core_done,
  output logic [NUM_CORES-1:0]                core_start,
  output logic [NUM_CORES-1:0]                core_reset,
  output logic [NUM_CORES*BLOCK_ID_WIDTH-1:0] core_block_id,
  output logic                                busy,
  output logic                                done,
  output logic [BLOCK_ID_WIDTH:0]             blocks_done
);

  localparam int CW         = BLOCK_ID_WIDTH + 1;
  localparam int MAX_BLOCKS = 1 << BLOCK_ID_WIDTH;

  sched_state_t              state;
  logic [CW-1:0]             num_blocks_q;
  logic [CW-1:0]             dispatched_q;
  logic [CW-1:0]             cfg_blocks;
  logic [CW-1:0]             launch_cnt;
  logic [CW-1:0]             done_cnt;
  logic [NUM_CORES-1:0]      slot_free;
  logic [NUM_CORES-1:0]      slot_completed;
  logic [NUM_CORES-1:0]      sel;
  logic [BLOCK_ID_WIDTH-1:0] sel_id [NUM_CORES];
  logic                      running;
  logic                      kill;
  int                        pick_cnt;

  assign running = (state == RUN);
  assign kill    = running && abort;

  // Counters must never wrap, so oversize requests are clamped.
  assign cfg_blocks = (int'(kernel_config.num_blocks) > MAX_BLOCKS) ?
                      CW'(MAX_BLOCKS) : CW'(kernel_config.num_blocks);

  // Lowest-index free slots win; each takes the next id in slot order.
  always_comb begin
    sel      = '0;
    pick_cnt = 0;
    for (int i = 0; i < NUM_CORES; i++) begin
      sel_id[i] = BLOCK_ID_WIDTH'(int'(dispatched_q) + pick_cnt);
      if (running && !abort && slot_free[i] && pick_cnt < LAUNCH_PER_CYCLE &&
          (int'(dispatched_q) + pick_cnt) < int'(num_blocks_q)) begin
        sel[i]   = 1'b1;
        pick_cnt = pick_cnt + 1;
      end
    end
    launch_cnt = CW'(pick_cnt);
  end

  assign done_cnt = CW'(popcount(16'(slot_completed)));

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      num_blocks_q <= '0;
      dispatched_q <= '0;
      blocks_done  <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start && !abort) begin
            num_blocks_q <= cfg_blocks;
            dispatched_q <= '0;
            blocks_done  <= '0;
            if (cfg_blocks == '0) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= RUN;
              busy  <= 1'b1;
              done  <= 1'b0;
            end
          end
        end
        RUN: begin
          if (abort) begin
            // completions in the abort cycle belong to a dead kernel
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
          end else begin
            dispatched_q <= dispatched_q + launch_cnt;
            blocks_done  <= blocks_done + done_cnt;
            if (blocks_done == num_blocks_q) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  for (genvar g = 0; g < NUM_CORES; g++) begin : g_slot
    core_slot #(
      .BLOCK_ID_WIDTH(BLOCK_ID_WIDTH)
    ) u_slot (
      .clk          (clk),
      .reset        (reset),
      .dispatch     (sel[g]),
      .block_id     (sel_id[g]),
      .run          (running),
      .kill         (kill),
      .core_done    (core_done[g]),
      .is_free      (slot_free[g]),
      .completed    (slot_completed[g]),
      .core_start   (core_start[g]),
      .core_reset   (core_reset[g]),
      .core_block_id(core_block_id[g*BLOCK_ID_WIDTH +: BLOCK_ID_WIDTH])
    );
  end

endmodule
